// File: rtl/binary_counter_if.sv
// -----------------------------------------------------------------------------
// binary_counter_if
//   Groups the control and status signals of binary_counter.
//
//   Handshake semantics: there is no valid/ready pair. The counter samples
//   en/up/clear/load/load_value on every rising clock edge, and value, tc
//   and wrapped are valid in every cycle.
//
//   Parameter:
//     NUM_BITS    counter width; must match the counter instance's NUM_BITS
//
//   Signals:
//     en          count enable
//     up          direction: 1 = up, 0 = down
//     clear       synchronous clear to 0 (highest priority)
//     load        synchronous parallel load
//     load_value  value written when load=1
//     value       current count
//     tc          terminal count (combinational)
//     wrapped     one-cycle pulse after a wrap (or clamp) edge
//
//   Modports:
//     master      drives the controls, observes the status (the user)
//     slave       the counter itself
// -----------------------------------------------------------------------------
interface binary_counter_if #(
  parameter int unsigned NUM_BITS = 4
) ();

  logic                en;
  logic                up;
  logic                clear;
  logic                load;
  logic [NUM_BITS-1:0] load_value;
  logic [NUM_BITS-1:0] value;
  logic                tc;
  logic                wrapped;

  modport master (
    output en,
    output up,
    output clear,
    output load,
    output load_value,
    input  value,
    input  tc,
    input  wrapped
  );

  modport slave (
    input  en,
    input  up,
    input  clear,
    input  load,
    input  load_value,
    output value,
    output tc,
    output wrapped
  );

endinterface

// File: rtl/binary_counter.sv
// -----------------------------------------------------------------------------
// binary_counter
//   Parameterised synchronous binary up/down counter with synchronous clear,
//   parallel load, a combinational terminal-count flag and a one-cycle wrap
//   pulse. Intended as a generic event/cycle counter and for cascading.
//
//   Parameters:
//     NUM_BITS    counter width, 1..32
//     STEP        increment/decrement amount (NUM_BITS wide, > 0)
//
//   Ports:
//     clk         rising-edge clock
//     reset       asynchronous active-low reset (0 = reset asserted)
//     bus         binary_counter_if.slave (en, up, clear, load, load_value in;
//                 value, tc, wrapped out)
//
//   Edge priority: clear > load > en > hold.
//
//   Build option:
//     BINARY_COUNTER_SATURATE_EN  when defined the counter clamps at 0 / MAX
//                                 instead of wrapping; wrapped then pulses on
//                                 every edge whose step was clamped.
// -----------------------------------------------------------------------------
module binary_counter #(
  parameter int unsigned         NUM_BITS = 4,
  parameter logic [NUM_BITS-1:0] STEP     = NUM_BITS'(1)
) (
  input  logic               clk,
  input  logic               reset,
  binary_counter_if.slave    bus
);

  localparam logic [NUM_BITS-1:0] MAX = '1;

  logic [NUM_BITS-1:0] value_q;
  logic [NUM_BITS-1:0] next_value;
  logic                wrapped_q;
  logic                next_wrapped;

  // The up sum is one bit wider so its carry-out is the overflow indicator.
  logic [NUM_BITS:0]   up_sum;
  logic                up_over;
  logic [NUM_BITS-1:0] down_diff;
  logic                down_under;

  assign up_sum     = {1'b0, value_q} + {1'b0, STEP};
  assign up_over    = up_sum[NUM_BITS];
  assign down_diff  = value_q - STEP;
  assign down_under = (value_q < STEP);

  // Next-state selection. wrapped defaults to 0 so that clear, load and hold
  // edges all drop the pulse; only a counting edge that crosses a boundary
  // raises it.
  always_comb begin
    next_value   = value_q;
    next_wrapped = 1'b0;
    if (bus.clear) begin
      next_value = '0;
    end else if (bus.load) begin
      next_value = bus.load_value;
    end else if (bus.en) begin
      if (bus.up) begin
        next_wrapped = up_over;
`ifdef BINARY_COUNTER_SATURATE_EN
        next_value   = up_over ? MAX : up_sum[NUM_BITS-1:0];
`else
        next_value   = up_sum[NUM_BITS-1:0];
`endif
      end else begin
        next_wrapped = down_under;
`ifdef BINARY_COUNTER_SATURATE_EN
        next_value   = down_under ? '0 : down_diff;
`else
        next_value   = down_diff;
`endif
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      value_q   <= '0;
      wrapped_q <= 1'b0;
    end else begin
      value_q   <= next_value;
      wrapped_q <= next_wrapped;
    end
  end

  assign bus.value   = value_q;
  assign bus.wrapped = wrapped_q;

  // tc looks ahead: it is high in the cycle whose edge would wrap or clamp.
  // It deliberately ignores clear/load so cascaded stages see a pure
  // function of count state, enable and direction.
  assign bus.tc = bus.en & (bus.up ? (value_q > (MAX - STEP)) : down_under);

endmodule

// File: tb/tb_binary_counter.sv
// -----------------------------------------------------------------------------
// tb_binary_counter
//   Self-checking bench for binary_counter (NUM_BITS=4, STEP=1).
//   Structure: clock/reset block, driver tasks, scoreboard queue of expected
//   {value, wrapped, tc} per cycle, a negedge monitor that pops and compares,
//   and a final report. The reference model tracks the count as a plain
//   integer and applies wrap/clamp rules arithmetically.
// -----------------------------------------------------------------------------
module tb_binary_counter;

  localparam int          W     = 4;
  localparam longint      STEPV = 1;
  localparam logic [W-1:0] STEP = W'(STEPV);
  localparam longint      MAXV  = (longint'(1) << W) - 1;
  localparam int unsigned MAXU  = (1 << W) - 1;
  localparam int          EW    = W + 2;

`ifdef BINARY_COUNTER_SATURATE_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  binary_counter_if #(.NUM_BITS(W)) bus ();

  binary_counter #(.NUM_BITS(W), .STEP(STEP)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // ---------------- scoreboard state ----------------
  logic [EW-1:0] exp_q[$];
  logic [EW-1:0] mon_e;
  int            checks   = 0;
  int            failures = 0;

  // Reference model: count as a plain integer, plus the wrap pulse.
  longint m_val = 0;
  bit     m_wr  = 1'b0;

  // Expected observation for the current cycle, given the inputs now driven.
  function automatic logic [EW-1:0] expect_now();
    bit t;
    if (!bus.en)     t = 1'b0;
    else if (bus.up) t = (m_val + STEPV) > MAXV;
    else             t = (m_val - STEPV) < 0;
    return {W'(m_val), m_wr, t};
  endfunction

  // Advance the model by one rising edge using the inputs held at that edge.
  function automatic void model_step();
    longint n;
    if (!reset || bus.clear) begin
      m_val = 0;
      m_wr  = 1'b0;
    end else if (bus.load) begin
      m_val = longint'(bus.load_value);
      m_wr  = 1'b0;
    end else if (bus.en) begin
      n = bus.up ? (m_val + STEPV) : (m_val - STEPV);
      if (n > MAXV || n < 0) begin
        m_wr = 1'b1;
        if (SAT) n = (n > MAXV) ? MAXV : 0;
        else     n = (n > MAXV) ? n - (MAXV + 1) : n + (MAXV + 1);
      end else begin
        m_wr = 1'b0;
      end
      m_val = n;
    end else begin
      m_wr = 1'b0;
    end
  endfunction

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (exp_q.size() != 0) begin
      mon_e = exp_q.pop_front();
      check("value",   bus.value,          mon_e[EW-1:2]);
      check("wrapped", W'(bus.wrapped),    W'(mon_e[1]));
      check("tc",      W'(bus.tc),         W'(mon_e[0]));
    end
  end

  // ---------------- driver tasks ----------------
  // Called just after a rising edge; drives one cycle's inputs.
  task automatic drive(input bit e, input bit u, input bit c, input bit l,
                       input logic [W-1:0] lv);
    bus.en         = e;
    bus.up         = u;
    bus.clear      = c;
    bus.load       = l;
    bus.load_value = lv;
    exp_q.push_back(expect_now());
    @(posedge clk);
    #1;
    model_step();
  endtask

  // Asserts reset in the middle of a cycle; value must drop before the edge.
  task automatic reset_mid(input bit e, input bit u);
    bus.en    = e;
    bus.up    = u;
    bus.clear = 1'b0;
    bus.load  = 1'b0;
    #2;
    reset = 1'b0;
    m_val = 0;
    m_wr  = 1'b0;
    exp_q.push_back(expect_now());
    @(posedge clk);
    #1;
    model_step();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    bus.en = 1'b0; bus.up = 1'b1; bus.clear = 1'b0; bus.load = 1'b0;
    bus.load_value = '0;
    @(posedge clk);
    #1;

    // Reset held: value 0, no pulse.
    drive(1, 1, 0, 0, '0);
    reset = 1'b1;
    // Count up from 0.
    for (int i = 0; i < 4; i++) drive(1, 1, 0, 0, '0);

    // Up through the top boundary.
    drive(1, 1, 0, 1, W'(14));
    for (int i = 0; i < 4; i++) drive(1, 1, 0, 0, '0);

    // Down through zero.
    drive(1, 0, 0, 1, W'(1));
    for (int i = 0; i < 4; i++) drive(1, 0, 0, 0, '0);

    // Load wins over enable, then counting resumes; clear beats load.
    drive(1, 1, 0, 1, W'(9));
    drive(1, 1, 0, 0, '0);
    drive(1, 1, 0, 0, '0);
    drive(1, 1, 1, 1, W'(12));
    drive(1, 1, 0, 0, '0);

    // Asynchronous reset mid-cycle at value 7, then release.
    drive(1, 1, 0, 1, W'(7));
    reset_mid(1, 1);
    reset = 1'b1;
    drive(1, 1, 0, 0, '0);
    drive(1, 1, 0, 0, '0);

    // Reset right after a wrap edge must also kill the pulse.
    drive(1, 1, 0, 1, W'(15));
    drive(1, 1, 0, 0, '0);
    reset_mid(0, 1);
    reset = 1'b1;

    // Hold with en=0 at value 5.
    drive(0, 1, 0, 1, W'(5));
    for (int i = 0; i < 5; i++) drive(0, $urandom_range(0, 1), 0, 0, '0);

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      int r;
      if (!reset) reset = 1'b1;
      r = int'($urandom_range(0, 99));
      if (r < 2) begin
        reset_mid($urandom_range(0, 1), $urandom_range(0, 1));
      end else begin
        drive($urandom_range(0, 3) != 0,
              $urandom_range(0, 1),
              (r < 6),
              ($urandom_range(0, 9) == 0),
              W'($urandom_range(0, MAXU)));
      end
    end
    reset = 1'b1;
    drive(0, 1, 0, 0, '0);

    // Let the monitor drain the queue, bounded.
    for (int i = 0; i < 4 && exp_q.size() != 0; i++) @(negedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
